// File: rtl/instruction_fetch_queue_if.sv
// rtl/instruction_fetch_queue_if.sv - fetch request, program-load and decoder handshake bundle for the fetch queue
interface instruction_fetch_queue_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] instruction_addr;
    logic              addr_valid;
    logic              flush;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_addr_out;
    logic              instr_valid;
    logic              instr_ready;
    logic              fetch_stall;
    logic [CNT_W-1:0]  count;

    modport master (
        output instruction_addr, addr_valid, flush,
        output imem_we, imem_waddr, imem_wdata, instr_ready,
        input  instr, instr_addr_out, instr_valid, fetch_stall, count
    );

    modport slave (
        input  instruction_addr, addr_valid, flush,
        input  imem_we, imem_waddr, imem_wdata, instr_ready,
        output instr, instr_addr_out, instr_valid, fetch_stall, count
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - instruction memory plus DEPTH-entry {addr, instr} FIFO toward the decoder
// Optional same-cycle empty-queue bypass: define IFQ_BYPASS_EN.
module instruction_fetch_queue #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic clk,
    input  logic rst,
    instruction_fetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q  [2**ADDR_W];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DATA_W-1:0] fetch_data;
    logic              full, empty, push, pop, bypass, store;

    // Write-first: a program-load write to the address being fetched is seen immediately.
    always_comb begin
        fetch_data = mem_q[bus.instruction_addr];
        if (bus.imem_we && (bus.imem_waddr == bus.instruction_addr)) begin
            fetch_data = bus.imem_wdata;
        end
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.addr_valid & ~full & ~bus.flush;
    assign pop   = ~empty & bus.instr_ready & ~bus.flush;

`ifdef IFQ_BYPASS_EN
    assign bypass = empty & push & bus.instr_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed fetch is consumed directly and never occupies a slot.
    assign store = push & ~bypass;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
            case ({store, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            mem_q[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && store) begin
            data_q[wr_ptr_q] <= fetch_data;
            addr_q[wr_ptr_q] <= bus.instruction_addr;
        end
    end

    always_comb begin
        bus.instr          = '0;
        bus.instr_addr_out = '0;
        if (bypass) begin
            bus.instr          = fetch_data;
            bus.instr_addr_out = bus.instruction_addr;
        end else if (!empty) begin
            bus.instr          = data_q[rd_ptr_q];
            bus.instr_addr_out = addr_q[rd_ptr_q];
        end
    end

    assign bus.instr_valid = ~empty | bypass;
    assign bus.fetch_stall = full;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - table vectors, corner sequences and randomized run against a queue model
module tb_instruction_fetch_queue;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_fetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    instruction_fetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } ent_t;

    typedef struct {
        bit         r, av;
        logic [3:0] a;
        bit         fl, we;
        logic [3:0] wa;
        logic [7:0] wd;
        bit         rdy;
        bit         ev;
        logic [7:0] ei;
        logic [3:0] ea;
        logic [2:0] ec;
        bit         es;
    } vec_t;

    ent_t       mq[$];
    logic [7:0] mmem [16];
    vec_t       tbl[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic vec_t mk(bit r, bit av, int a, bit fl, bit we, int wa, int wd, bit rdy,
                                bit ev, int ei, int ea, int ec, bit es);
        vec_t v;
        v.r = r; v.av = av; v.a = 4'(a); v.fl = fl; v.we = we; v.wa = 4'(wa); v.wd = 8'(wd);
        v.rdy = rdy; v.ev = ev; v.ei = 8'(ei); v.ea = 4'(ea); v.ec = 3'(ec); v.es = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst                  = v.r;
        bus.addr_valid       = v.av;
        bus.instruction_addr = v.a;
        bus.flush            = v.fl;
        bus.imem_we          = v.we;
        bus.imem_waddr       = v.wa;
        bus.imem_wdata       = v.wd;
        bus.instr_ready      = v.rdy;
    endtask

    // One clock: outputs checked at negedge against the model (and optionally the vector), then the model advances.
    task automatic step(input vec_t v, input bit mcheck, input bit tcheck, input string tag);
        int         sz;
        logic [7:0] fd;
        bit         byp, e_valid, do_push, do_pop;
        logic [7:0] e_instr;
        logic [3:0] e_addr;
        drive(v);
        sz  = mq.size();
        fd  = (v.we && v.wa == v.a) ? v.wd : mmem[v.a];
        byp = BYP && sz == 0 && v.av && v.rdy && !v.fl;
        e_valid = byp || sz > 0;
        e_instr = byp ? fd  : (sz > 0 ? mq[0].d : 8'h00);
        e_addr  = byp ? v.a : (sz > 0 ? mq[0].a : 4'h0);
        @(negedge clk);
        if (mcheck) begin
            chk({tag, "_m_valid"}, 32'(bus.instr_valid), 32'(e_valid));
            chk({tag, "_m_instr"}, 32'(bus.instr), 32'(e_instr));
            chk({tag, "_m_addr"},  32'(bus.instr_addr_out), 32'(e_addr));
            chk({tag, "_m_count"}, 32'(bus.count), 32'(sz));
            chk({tag, "_m_stall"}, 32'(bus.fetch_stall), 32'(sz == DEPTH));
        end
        if (tcheck) begin
            chk({tag, "_valid"}, 32'(bus.instr_valid), 32'(v.ev));
            chk({tag, "_instr"}, 32'(bus.instr), 32'(v.ei));
            chk({tag, "_addr"},  32'(bus.instr_addr_out), 32'(v.ea));
            chk({tag, "_count"}, 32'(bus.count), 32'(v.ec));
            chk({tag, "_stall"}, 32'(bus.fetch_stall), 32'(v.es));
        end
        @(posedge clk);
        if (v.r || v.fl) begin
            mq.delete();
        end else begin
            do_push = v.av && sz < DEPTH;
            do_pop  = sz > 0 && v.rdy;
            if (do_pop) void'(mq.pop_front());
            if (do_push && !byp) mq.push_back('{a: v.a, d: fd});
        end
        if (v.we) mmem[v.wa] = v.wd;
        #1;
    endtask

    initial begin
        vec_t v;
        step(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0), 1'b0, 1'b0, "rst0");
        step(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0), 1'b0, 1'b0, "rst1");
        for (int i = 0; i < 16; i++) begin
            step(mk(0,0,0,0,1,i,'h11*(i+1),0, 0,0,0,0,0), 1'b1, 1'b0, $sformatf("load%0d", i));
        end

        // reset/idle state
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0));
        // streaming fetch with ready high
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,0,0,1, 1,'h11,0,1,0));
        tbl.push_back(mk(0,1,2,0,0,0,0,1, 1,'h22,1,1,0));
        tbl.push_back(mk(0,1,3,0,0,0,0,1, 1,'h33,2,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,'h44,3,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0));
        // fill to full, drops while full, full+pop blocks push
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,0,0,0, 1,'h11,0,1,0));
        tbl.push_back(mk(0,1,2,0,0,0,0,0, 1,'h11,0,2,0));
        tbl.push_back(mk(0,1,3,0,0,0,0,0, 1,'h11,0,3,0));
        tbl.push_back(mk(0,1,4,0,0,0,0,0, 1,'h11,0,4,1));
        tbl.push_back(mk(0,1,5,0,0,0,0,0, 1,'h11,0,4,1));
        tbl.push_back(mk(0,1,6,0,0,0,0,1, 1,'h11,0,4,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,'h22,1,3,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,'h33,2,2,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,'h44,3,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0));
        // flush with count=3 and a same-cycle fetch and ready
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,0,0,0, 1,'h11,0,1,0));
        tbl.push_back(mk(0,1,2,0,0,0,0,0, 1,'h11,0,2,0));
        tbl.push_back(mk(0,1,2,1,0,0,0,1, 1,'h11,0,3,0));
        tbl.push_back(mk(0,1,3,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,'h44,3,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,'h44,3,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0));
        // write-first bypass of the memory
        tbl.push_back(mk(0,1,5,0,1,5,'hA5,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,'hA5,5,1,0));
        tbl.push_back(mk(0,1,5,0,0,0,0,1, 1,'hA5,5,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,'hA5,5,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,'hA5,5,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0));
        // reset mid-stream, memory retained
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,0,0,0, 1,'h11,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,'h11,0,2,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,'h11,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,'h11,0,1,0));
        foreach (tbl[i]) step(tbl[i], 1'b1, 1'b1, $sformatf("tbl%0d", i));

        // empty queue, ready high: latency 0 with bypass, 1 without
        v = BYP ? mk(0,1,2,0,0,0,0,1, 1,'h33,2,0,0) : mk(0,1,2,0,0,0,0,1, 0,0,0,0,0);
        step(v, 1'b1, 1'b1, "byp0");
        v = BYP ? mk(0,0,0,0,0,0,0,1, 0,0,0,0,0) : mk(0,0,0,0,0,0,0,1, 1,'h33,2,1,0);
        step(v, 1'b1, 1'b1, "byp1");
        step(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0), 1'b1, 1'b1, "byp2");

        for (int i = 0; i < 800; i++) begin
            v = mk(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 15),
                   ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 15),
                   $urandom_range(0, 255), ($urandom_range(0, 1) == 1), 0,0,0,0,0);
            step(v, 1'b1, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
